// File: rtl/lc3_mem_arbiter.sv
// Single-port LC-3 memory arbiter: memory-stage accesses (direct and indirect)
// take priority over instruction fetch; a taken branch squashes the fetch in flight.
module lc3_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              br_taken,
    input  logic              ms_req,
    input  logic              ms_we,
    input  logic              ms_ind,
    input  logic [ADDR_W-1:0] ms_addr,
    input  logic [DATA_W-1:0] ms_wdata,
    input  logic [DATA_W-1:0] m_dout,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    output logic              m_rd,
    output logic              m_we,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic              ms_done,
    output logic [DATA_W-1:0] ms_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PTR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_pend;
    logic              r_kill;
    logic              w_slot;
    logic              w_rd;
    logic              w_we;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;

    // Port steering. DONE is a fetch slot so a back-to-back requester cannot starve Fetch.
    always_comb begin
        w_next = r_state;
        w_addr = '0;
        w_din  = '0;
        w_rd   = 1'b0;
        w_we   = 1'b0;
        w_gnt  = 1'b0;
        w_slot = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ms_req) begin
                    w_addr = ms_addr;
                    if (ms_ind) begin
                        w_rd   = 1'b1;
                        w_next = S_PTR;
                    end else begin
                        w_we   = ms_we;
                        w_rd   = !ms_we;
                        w_din  = ms_wdata;
                        w_next = S_DONE;
                    end
                end else begin
                    w_slot = 1'b1;
                end
            end
            S_PTR: begin
                w_addr = ADDR_W'(m_dout);
                w_we   = ms_we;
                w_rd   = !ms_we;
                w_din  = ms_wdata;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_slot = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_slot && if_req) begin
            w_addr = if_addr;
            w_rd   = 1'b1;
            w_gnt  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_gnt;
            r_kill  <= br_taken;
        end
    end

    // Everything is forced low while reset is held, including the combinational strobes.
    assign m_addr   = reset ? w_addr : '0;
    assign m_din    = reset ? w_din  : '0;
    assign m_rd     = reset & w_rd;
    assign m_we     = reset & w_we;
    assign if_gnt   = reset & w_gnt;
    assign if_valid = reset & r_pend & !r_kill & !br_taken;
    assign if_instr = reset ? m_dout : '0;
    assign ms_done  = reset & (r_state == S_DONE);
    assign ms_rdata = ms_done ? m_dout : '0;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Randomized bench for lc3_mem_arbiter: transaction-level model of fetch and
// memory-stage traffic against a reference memory image.
module tb_lc3_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        br_taken = 1'b0;
    logic        ms_req = 1'b0;
    logic        ms_we = 1'b0;
    logic        ms_ind = 1'b0;
    logic [15:0] ms_addr = '0;
    logic [15:0] ms_wdata = '0;
    logic [15:0] m_dout;
    logic [15:0] m_addr;
    logic [15:0] m_din;
    logic        m_rd;
    logic        m_we;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        ms_done;
    logic [15:0] ms_rdata;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .br_taken(br_taken), .ms_req(ms_req), .ms_we(ms_we), .ms_ind(ms_ind),
        .ms_addr(ms_addr), .ms_wdata(ms_wdata), .m_dout(m_dout), .m_addr(m_addr),
        .m_din(m_din), .m_rd(m_rd), .m_we(m_we), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_instr(if_instr), .ms_done(ms_done), .ms_rdata(ms_rdata)
    );

    always #5 clock = ~clock;

    // Initial memory image: pointer table at 0x4010..0x402F points into 0x5000..0x50FF.
    function automatic logic [15:0] initv(input logic [15:0] a);
        if (a == 16'h4000) return 16'h1234;
        if (a == 16'h4010) return 16'h5000;
        if (a > 16'h4010 && a <= 16'h402F) return {8'h50, a[7:0] ^ 8'h3C};
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Environment memory: one port, read data appears the cycle after m_rd.
    logic [15:0] mem [0:65535];
    bit          wr  [0:65535];
    always @(posedge clock) begin
        if (m_we) begin
            mem[m_addr] <= m_din;
            wr[m_addr]  <= 1'b1;
        end
        if (m_rd) m_dout <= wr[m_addr] ? mem[m_addr] : initv(m_addr);
    end

    function automatic logic [15:0] envrd(input logic [15:0] a);
        return wr[a] ? mem[a] : initv(a);
    endfunction

    typedef struct {
        logic        we;
        logic        ind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ptr;
        logic [15:0] data;
    } op_t;

    logic [15:0] refmem [0:65535];
    op_t         dq[$];
    op_t         op;
    bit          ms_active = 0;
    int          age = 0;
    bit          f_pend = 0;
    bit          f_kill = 0;
    logic [15:0] f_instr = '0;
    logic [15:0] pc = 16'h3000;
    logic [15:0] br_tgt = 16'h3000;
    bit          force_br = 0;
    int          p_if = 100, p_ms = 0, p_br = 0;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic we, input logic ind, input logic [15:0] addr,
                                  input logic [15:0] wdata);
        op_t o;
        o.we = we; o.ind = ind; o.addr = addr; o.wdata = wdata; o.ptr = '0; o.data = '0;
        return o;
    endfunction

    function automatic op_t rnd_op();
        logic        ind;
        logic [15:0] a;
        ind = 1'($urandom_range(1));
        if (ind) a = 16'(16'h4010 + $urandom_range(31));
        else if ($urandom_range(9) == 0) a = 16'hFFFF;
        else a = 16'(16'h5000 + $urandom_range(255));
        return mk_op(1'($urandom_range(1)), ind, a, 16'($urandom));
    endfunction

    task automatic drive();
        if_req   = (int'($urandom_range(99)) < p_if);
        if_addr  = pc;
        br_taken = force_br || (int'($urandom_range(99)) < p_br);
        if (br_taken && !force_br) br_tgt = 16'(16'h3000 + $urandom_range(255));
        if (!ms_active) begin
            if (dq.size() > 0) begin
                op = dq.pop_front(); ms_active = 1; age = 0;
            end else if (int'($urandom_range(99)) < p_ms) begin
                op = rnd_op(); ms_active = 1; age = 0;
            end
        end
        ms_req = ms_active;
        if (ms_active) begin
            ms_we = op.we; ms_ind = op.ind; ms_addr = op.addr; ms_wdata = op.wdata;
        end else begin
            ms_we = 1'($urandom_range(1)); ms_ind = 1'($urandom_range(1));
            ms_addr = 16'($urandom); ms_wdata = 16'($urandom);
        end
    endtask

    // Expected port behaviour from the transaction's age: direct = issue, done;
    // indirect = pointer read, data access, done. Done cycles and idle cycles serve Fetch.
    task automatic check_cycle();
        logic        e_gnt, e_rd, e_we, e_done, e_valid, data_ph;
        logic [15:0] e_addr;
        e_gnt = 0; e_rd = 0; e_we = 0; e_done = 0; data_ph = 0; e_addr = '0;
        if (ms_active && age == 0) begin
            e_addr = op.addr;
            if (op.ind) e_rd = 1;
            else begin e_we = op.we; e_rd = !op.we; data_ph = 1; end
        end else if (ms_active && op.ind && age == 1) begin
            e_addr = op.ptr; e_we = op.we; e_rd = !op.we; data_ph = 1;
        end else begin
            e_done = ms_active;
            if (if_req) begin e_gnt = 1; e_rd = 1; e_addr = if_addr; end
        end
        e_valid = f_pend && !f_kill && !br_taken;

        chk("m_rd", m_rd, e_rd);
        chk("m_we", m_we, e_we);
        if (e_rd || e_we) chk("m_addr", m_addr, e_addr);
        if (e_we) chk("m_din", m_din, op.wdata);
        chk("if_gnt", if_gnt, e_gnt);
        chk("ms_done", ms_done, e_done);
        if (e_done && !op.we) chk("ms_rdata", ms_rdata, op.data);
        chk("if_valid", if_valid, e_valid);
        if (e_valid) chk("if_instr", if_instr, f_instr);

        if (ms_active && op.ind && age == 0) op.ptr = refmem[op.addr];
        if (data_ph) begin
            if (op.we) refmem[e_addr] = op.wdata;
            else op.data = refmem[e_addr];
        end
        f_pend = e_gnt;
        f_kill = br_taken;
        if (e_gnt) f_instr = refmem[if_addr];
        if (ms_active) begin
            if (e_done) ms_active = 0;
            else age++;
        end
        if (br_taken) pc = br_tgt;
        else if (e_gnt) pc = pc + 16'd1;
    endtask

    task automatic step();
        @(posedge clock);
        #1 drive();
        #1 check_cycle();
    endtask

    task automatic reset_check(input string tag);
        @(posedge clock);
        #1;
        reset = 1'b0; if_req = 1; ms_req = 1; ms_ind = 1; ms_we = 0; br_taken = 1;
        #1;
        chk({tag, "_m_rd"}, m_rd, 1'b0);
        chk({tag, "_m_we"}, m_we, 1'b0);
        chk({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_ms_done"}, ms_done, 1'b0);
        chk({tag, "_m_addr"}, m_addr, 16'h0);
        chk({tag, "_m_din"}, m_din, 16'h0);
        chk({tag, "_if_instr"}, if_instr, 16'h0);
        chk({tag, "_ms_rdata"}, ms_rdata, 16'h0);
        if_req = 0; ms_req = 0; br_taken = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        ms_active = 0; f_pend = 0; f_kill = 0;
        dq.delete();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) refmem[a] = initv(16'(a));
        reset_check("rst0");

        // Continuous fetch from 0x3000.
        pc = 16'h3000; p_if = 100; p_ms = 0; p_br = 0;
        repeat (8) step();

        // Direct load of 0x4000 while Fetch is requesting.
        dq.push_back(mk_op(1'b0, 1'b0, 16'h4000, 16'h0));
        repeat (4) step();

        // Indirect store through 0x4010 -> 0x5000.
        dq.push_back(mk_op(1'b1, 1'b1, 16'h4010, 16'hBEEF));
        repeat (5) step();
        chk("st_beef", envrd(16'h5000), 16'hBEEF);

        // Indirect load immediately followed by a direct load.
        dq.push_back(mk_op(1'b0, 1'b1, 16'h4011, 16'h0));
        dq.push_back(mk_op(1'b0, 1'b0, 16'h5003, 16'h0));
        repeat (7) step();

        // Branch squash in the return cycle of the 0x3005 fetch.
        pc = 16'h3005;
        step();
        force_br = 1; br_tgt = 16'h3100;
        step();
        force_br = 0;
        repeat (3) step();

        // Reset while the indirect store is in its pointer phase.
        dq.push_back(mk_op(1'b1, 1'b1, 16'h4012, 16'hCAFE));
        step();
        reset_check("rst_ptr");
        repeat (3) step();

        p_if = 70; p_ms = 25; p_br = 10;
        repeat (3000) step();
        p_ms = 0; p_br = 0;
        repeat (6) step();

        for (int a = 16'h5000; a < 16'h5100; a++) chk("mem", envrd(16'(a)), refmem[a]);
        chk("mem_ffff", envrd(16'hFFFF), refmem[16'hFFFF]);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Arbiter and sequencer for the single-ported unified LC-3 memory in the pipelined design. It shares the memory between the Fetch stage (instruction reads, one per cycle) and the memory-access stage (LD/ST/LDR/STR/LDI/STI). Memory-stage requests have priority. Indirect accesses are sequenced as two back-to-back memory cycles. An in-flight instruction fetch is squashed when a branch is taken.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  Fetch requests the instruction at if_addr
- if_addr  in  16  Fetch PC
- br_taken  in  1  branch taken; squashes the in-flight fetch
- ms_req  in  1  memory-stage request, held high until ms_done
- ms_we  in  1  1 = store, 0 = load
- ms_ind  in  1  1 = indirect (LDI/STI)
- ms_addr  in  16  effective address (pointer address when ms_ind=1)
- ms_wdata  in  16  store data
- m_dout  in  16  memory read data; valid the cycle after m_rd
- m_addr  out  16  memory address
- m_din  out  16  memory write data
- m_rd  out  1  memory read strobe
- m_we  out  1  memory write strobe
- if_gnt  out  1  fetch issued this cycle; Fetch may advance its PC
- if_valid  out  1  if_instr valid this cycle
- if_instr  out  16  fetched instruction
- ms_done  out  1  one-cycle completion pulse for the memory-stage access
- ms_rdata  out  16  load data, valid while ms_done=1 and the access is a load

## Operation
- State machine with three states:
  - IDLE (reset state)
  - PTR: pointer read returning
  - DONE: final data access returning
- IDLE, ms_req=1, ms_ind=0:
  - drive m_addr=ms_addr; assert m_we=ms_we and m_rd=!ms_we; m_din=ms_wdata
  - next state DONE
- IDLE, ms_req=1, ms_ind=1:
  - m_addr=ms_addr, m_rd=1
  - next state PTR
- PTR:
  - m_addr=m_dout (the pointer); m_we=ms_we, m_rd=!ms_we, m_din=ms_wdata
  - next state DONE
- DONE:
  - ms_done=1 and ms_rdata=m_dout; the requester drops ms_req in the same cycle
  - ms_req is ignored in DONE, so fetch is guaranteed one slot between data accesses (no fetch starvation)
  - next state IDLE
- Fetch grant in IDLE with ms_req=0, or in DONE:
  - when if_req=1: m_addr=if_addr, m_rd=1, if_gnt=1
  - otherwise the port is idle (m_rd=m_we=0)
- if_gnt is never asserted in PTR, nor in IDLE while ms_req=1. Fetch treats !if_gnt as a stall.
- Fetch return:
  - register pend=if_gnt and kill=br_taken at the grant edge
  - in the following cycle, if_valid = pend & !kill & !br_taken, and if_instr = m_dout
- Squashed fetches still consume their memory cycle. Only if_valid is suppressed.
- ms_we, ms_ind and ms_wdata are sampled combinationally. The requester holds them stable from request until ms_done.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, pend=0, kill=0.
  - All outputs are 0 while reset=0, including m_rd, m_we, if_gnt, if_valid and ms_done.
  - The first grant is possible in the cycle after reset deasserts.
- Fetch: grant in cycle N, if_valid in cycle N+1. Sustained throughput is 1 instruction per cycle.
- Direct load/store: issue in N, ms_done in N+1. Latency 2 cycles including the issue cycle.
- Indirect: pointer read in N, data access in N+1, ms_done in N+2.
- DONE overlaps a fetch grant, so the instruction after a load/store is requested in the same cycle as ms_done.
- Boundary conditions:
  - if_req and ms_req both high in IDLE: memory stage wins; if_gnt=0.
  - br_taken in the grant cycle or the return cycle: if_valid=0.
  - br_taken while in PTR: no effect on the data access.
  - reset asserted mid-access: the FSM returns to IDLE immediately, with no ms_done. The in-progress store is lost only if its m_we cycle had not yet occurred.
  - Address 16'hFFFF is treated as an ordinary address (no wrap logic needed).

## Test plan
- Reset then continuous fetch: if_req=1, if_addr=0x3000, 0x3001, … -> if_gnt=1 every cycle; if_valid the next cycle with if_instr=mem[addr].
- Direct load: mem[0x4000]=0x1234; ms_req=1, ms_we=0, ms_addr=0x4000 while if_req=1 -> if_gnt=0 for 1 cycle; ms_done=1 with ms_rdata=0x1234 one cycle later; if_gnt=1 in that same cycle.
- Indirect store: mem[0x4010]=0x5000; ms_ind=1, ms_we=1, ms_wdata=0xBEEF -> m_rd at 0x4010, then m_we at 0x5000 with 0xBEEF; ms_done in cycle 3; afterwards mem[0x5000]=0xBEEF.
- Indirect load back-to-back with a direct load (ms_req held, then re-raised) -> one fetch grant is inserted between the two accesses.
- Branch squash: grant at 0x3005, br_taken=1 in the return cycle -> if_valid=0; next grant at taddr=0x3100 returns valid.
- Reset asserted in PTR -> all outputs 0 at once, no ms_done; after release, the first fetch grant occurs normally.
